// File: rtl/fu_cdb_arbiter_pkg.sv
// Shared types and defaults for the functional-unit to CDB arbiter.
package fu_cdb_arbiter_pkg;

   localparam int XLEN      = 32;
   localparam int DEF_N_FU  = 4;
   localparam int DEF_N_CDB = 2;
   localparam int DEF_TAG_W = 5;

   // Result packet produced by each functional unit.
   typedef struct packed {
      logic [XLEN-1:0] alu_result;
      logic            take_branch;
   } FU_RS_PACKET;

   // One common-data-bus broadcast.
   typedef struct packed {
      logic                 valid;
      logic [DEF_TAG_W-1:0] tag;
      logic [XLEN-1:0]      value;
      logic                 take_branch;
   } CDB_PACKET;

   // (base + offset) mod n, for base < n and offset <= n.
   function automatic int wrap_index(input int base, input int offset, input int n);
      int sum;
      sum = base + offset;
      return (sum >= n) ? sum - n : sum;
   endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Round-robin multi-grant picker: starting at ptr, grants the first N_CDB
// requesters in circular order; the k-th grant is reported on port k.
module cdb_rr_picker
   import fu_cdb_arbiter_pkg::*;
#(
   parameter int N_FU  = DEF_N_FU,
   parameter int N_CDB = DEF_N_CDB,
   parameter int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1
) (
   input  logic [N_FU-1:0]             req,
   input  logic [PTR_W-1:0]            ptr,
   output logic [N_FU-1:0]             grant,
   output logic [N_CDB-1:0][PTR_W-1:0] port_idx,
   output logic [N_CDB-1:0]            port_valid
);

   // Circular scan from ptr, handing out ports in the order requesters are found.
   always_comb begin
      int n_found;
      // NOTE: every output gets a default before the loops so no path can leave a latch.
      grant      = '0;
      port_idx   = '0;
      port_valid = '0;
      n_found    = 0;
      for (int s = 0; s < N_FU; s++) begin
         for (int i = 0; i < N_FU; i++) begin
            if (i == wrap_index(int'(ptr), s, N_FU) && req[i] && n_found < N_CDB) begin
               grant[i] = 1'b1;
               for (int k = 0; k < N_CDB; k++) begin
                  if (k == n_found) begin
                     port_idx[k]   = PTR_W'(i);
                     port_valid[k] = 1'b1;
                  end
               end
               n_found = n_found + 1;
            end
         end
      end
   end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// Functional-unit result arbiter: each FU owns one holding slot; up to N_CDB
// occupied slots are broadcast per cycle on registered CDB ports, with a
// round-robin pointer for fairness.
module fu_cdb_arbiter
   import fu_cdb_arbiter_pkg::*;
#(
   parameter int N_FU  = DEF_N_FU,
   parameter int N_CDB = DEF_N_CDB,
   parameter int TAG_W = DEF_TAG_W   // must match DEF_TAG_W, the CDB_PACKET tag width
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        squash,
   input  logic [N_FU-1:0]             fu_result_valid,
   input  FU_RS_PACKET [N_FU-1:0]      fu_rs,
   input  logic [N_FU-1:0][TAG_W-1:0]  fu_tag,
   output logic [N_FU-1:0]             fu_ack,
   output CDB_PACKET [N_CDB-1:0]       cdb
);

   localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

   logic [N_FU-1:0]             buf_v;
   logic [N_FU-1:0][TAG_W-1:0]  buf_tag;
   logic [N_FU-1:0][XLEN-1:0]   buf_value;
   logic [N_FU-1:0]             buf_br;
   logic [PTR_W-1:0]            rr_ptr;
   logic [PTR_W-1:0]            rr_ptr_next;

   logic [N_FU-1:0]             grant;
   logic [N_CDB-1:0][PTR_W-1:0] port_idx;
   logic [N_CDB-1:0]            port_valid;
   CDB_PACKET [N_CDB-1:0]       cdb_next;

   cdb_rr_picker #(
      .N_FU  (N_FU),
      .N_CDB (N_CDB),
      .PTR_W (PTR_W)
   ) u_picker (
      .req        (buf_v),
      .ptr        (rr_ptr),
      .grant      (grant),
      .port_idx   (port_idx),
      .port_valid (port_valid)
   );

   // A slot accepts a new result when it is empty or draining this cycle;
   // nothing is accepted during a squash or while reset is held.
   assign fu_ack = fu_result_valid & (~buf_v | grant) & {N_FU{~squash & reset}};

   // Gather granted slot contents per port and advance the pointer past the last grant.
   always_comb begin
      logic [PTR_W-1:0] last_idx;
      last_idx = rr_ptr;
      for (int k = 0; k < N_CDB; k++) begin
         cdb_next[k] = '0;
         if (port_valid[k]) begin
            cdb_next[k].valid       = 1'b1;
            cdb_next[k].tag         = buf_tag[port_idx[k]];
            cdb_next[k].value       = buf_value[port_idx[k]];
            cdb_next[k].take_branch = buf_br[port_idx[k]];
            last_idx                = port_idx[k];
         end
      end
      rr_ptr_next = PTR_W'(wrap_index(int'(last_idx), 1, N_FU));
   end

   // Slot occupancy and round-robin pointer.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: state is updated with <= so every register samples pre-edge values whatever the block order.
      if (!reset) begin
         buf_v  <= '0;
         rr_ptr <= '0;
      end else if (squash) begin
         buf_v  <= '0;
         rr_ptr <= '0;
      end else begin
         for (int i = 0; i < N_FU; i++) begin
            if (fu_ack[i])
               buf_v[i] <= 1'b1;     // fill, including drain-and-refill
            else if (grant[i])
               buf_v[i] <= 1'b0;     // drained with nothing behind it
         end
         if (|grant)
            rr_ptr <= rr_ptr_next;
      end
   end

   // Slot payload capture on acknowledge.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: payload registers are reset as well so no X ever reaches the CDB in simulation.
      if (!reset) begin
         buf_tag   <= '0;
         buf_value <= '0;
         buf_br    <= '0;
      end else begin
         for (int i = 0; i < N_FU; i++) begin
            if (fu_ack[i]) begin
               buf_tag[i]   <= fu_tag[i];
               buf_value[i] <= fu_rs[i].alu_result;
               buf_br[i]    <= fu_rs[i].take_branch;
            end
         end
      end
   end

   // Registered CDB broadcast; each result is presented for exactly one cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cdb <= '0;
      else if (squash)
         cdb <= '0;
      else
         cdb <= cdb_next;
   end

endmodule
